cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
Shares the single 128b line-wide memory port between two cache controllers (port 0 = instruction cache, port 1 = data cache), each using the cache's level-held read/write plus ready handshake. Selects one requester per transaction, locks the grant until the memory completes, routes address, data and ready signals, then re-arbitrates. It sits between the cache instances and the memory model/controller.

Parameters:
ADDR_W, 32, address width.
LINE_W, 128, cache line width in bits.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-low reset (asserted when 0).
i_c0_read / i_c1_read  in  1  per-requester line read request, held high until its r_ready.
i_c0_write / i_c1_write  in  1  per-requester line writeback request, held high until its w_ready.
i_c0_addr / i_c1_addr  in  ADDR_W  line address.
i_c0_writedata / i_c1_writedata  in  LINE_W  writeback line.
o_c0_data / o_c1_data  out  LINE_W  read line returned to the requester.
o_c0_r_ready / o_c1_r_ready  out  1  read complete, one cycle.
o_c0_w_ready / o_c1_w_ready  out  1  write complete, one cycle.
o_mem_read  out  1  memory read request.
o_mem_write  out  1  memory write request.
o_mem_addr  out  ADDR_W  memory address.
o_mem_writedata  out  LINE_W  memory write line.
i_mem_data  in  LINE_W  memory read line.
i_mem_r_ready  in  1  memory read done.
i_mem_w_ready  in  1  memory write done.
o_owner  out  1  current or last grant (debug).

Behaviour:
- Reset (reset==0 at posedge): state IDLE; o_mem_read, o_mem_write, o_mem_addr and o_mem_writedata are 0; o_owner=0; the priority pointer selects port 0. Reset mid-transaction abandons the transaction, with no ready pulse to any requester.
- States: IDLE, READ, WRITE, RELEASE.
- IDLE: a port is requesting if read|write is high. Grant rules:
  - Only one port requesting: that port wins.
  - Both requesting: the port at the priority pointer wins.
  - Winner has both write and read high: write wins.
- At the grant edge, register owner, addr and writedata (mem side), set o_mem_write or o_mem_read, and go to WRITE or READ. The memory sees the request 1 cycle after the first requesting cycle.
- Memory outputs are registered and stay stable for the whole transaction. Requester input changes during the transaction are ignored.
- READ:
  - o_cN_r_ready = i_mem_r_ready & (owner==N), combinational, same cycle.
  - o_cN_data = i_mem_data for both ports. It is valid only alongside r_ready.
  - On i_mem_r_ready: clear o_mem_read and go to RELEASE.
- WRITE: o_cN_w_ready = i_mem_w_ready & (owner==N). On i_mem_w_ready: clear o_mem_write and go to RELEASE.
- RELEASE:
  - Lasts 1 cycle so the requester can drop its held level. Nothing is granted.
  - The priority pointer moves to the non-owner (round robin).
  - Then go to IDLE.
- Requests are never granted from RELEASE, so back-to-back transactions have a minimum 2-cycle gap: ready cycle M, RELEASE M+1, IDLE M+2, next mem request M+3.
- Ready pulses for the non-owner are always 0. Memory ready seen in IDLE or RELEASE is ignored.
- Writeback-then-fetch from one cache is two separate transactions. The other port may win in between.

Optional Feature:
- Macro CACHE_ARB_FIXED_PRIO_EN.
- Defined: the pointer is not updated and port 1 (data cache) always wins a tie.
- Undefined: round robin as above.
- All other behaviour is identical.

Decomposition:
- Package cache_arb_pkg:
  - State enum arb_state_t {IDLE, READ, WRITE, RELEASE}.
  - Localparams for the port indices, PORT_ICACHE=0 and PORT_DCACHE=1.
- One sub-module, arb_rr2: the 2-way grant picker. It takes two request bits, the pointer and the macro-selected mode, and returns the grant index.

Test Plan:
- Single read: c0 read to addr 0x0000_1230; memory returns 0xAAAA… after 3 cycles.
  -> o_mem_read rises 1 cycle after the request with o_mem_addr=0x1230; o_c0_r_ready pulses 1 cycle with o_c0_data=0xAAAA…; o_c1_r_ready stays 0.
- Simultaneous reads: c0 and c1 read out of reset.
  -> c0 is served first, then c1 starting 2 cycles after c0's ready. A third simultaneous pair is served c0 then c1 again, and the pointer alternates correctly.
- Write precedence: c1 asserts read and write together with writedata 0x5555….
  -> o_mem_write is issued first with o_mem_writedata=0x5555…; the read follows as a separate transaction.
- Input stability: c0 changes i_c0_addr mid-transaction.
  -> o_mem_addr is unchanged until completion.
- Reset mid-op: reset=0 during READ.
  -> next cycle all mem outputs are 0, state is IDLE, and no r_ready is issued. With CACHE_ARB_FIXED_PRIO_EN, repeated ties are always granted to c1.

Source files
------------

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the two-port cache/memory arbiter.
// Optional build macro: CACHE_ARB_FIXED_PRIO_EN (fixed data-cache priority on ties).
package cache_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WRITE   = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    localparam logic PORT_ICACHE = 1'b0;
    localparam logic PORT_DCACHE = 1'b1;

`ifdef CACHE_ARB_FIXED_PRIO_EN
    localparam logic FIXED_PRIO = 1'b1;
`else
    localparam logic FIXED_PRIO = 1'b0;
`endif

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Line-wide memory port bundle between the arbiter (master) and the
// memory model/controller (slave).
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) ();

    logic              o_mem_read;
    logic              o_mem_write;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [LINE_W-1:0] o_mem_writedata;
    logic [LINE_W-1:0] i_mem_data;
    logic              i_mem_r_ready;
    logic              i_mem_w_ready;

    modport master (
        output o_mem_read,
        output o_mem_write,
        output o_mem_addr,
        output o_mem_writedata,
        input  i_mem_data,
        input  i_mem_r_ready,
        input  i_mem_w_ready
    );

    modport slave (
        input  o_mem_read,
        input  o_mem_write,
        input  o_mem_addr,
        input  o_mem_writedata,
        output i_mem_data,
        output i_mem_r_ready,
        output i_mem_w_ready
    );

endinterface

// File: rtl/cache_mem_arbiter_arb_rr2.sv
// Two-way grant picker: a lone requester always wins; on a tie the winner
// is the pointer port, or the data cache when fixed priority is selected.
module arb_rr2
    import cache_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       fixed_prio,
    output logic       grant
);

    // Pick the winning port index from the request pair.
    always_comb begin
        grant = ptr;
        case (req)
            2'b01:   grant = PORT_ICACHE;
            2'b10:   grant = PORT_DCACHE;
            2'b11:   grant = fixed_prio ? PORT_DCACHE : ptr;
            default: grant = ptr;
        endcase
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one line-wide memory port between the instruction cache (port 0)
// and the data cache (port 1). One transaction is granted at a time, the
// grant is held until memory completes, then a one-cycle RELEASE gap lets
// the requester drop its level before re-arbitration.
// Optional build macro: CACHE_ARB_FIXED_PRIO_EN (pointer frozen, port 1 wins ties).
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_c0_read,
    input  logic              i_c0_write,
    input  logic [ADDR_W-1:0] i_c0_addr,
    input  logic [LINE_W-1:0] i_c0_writedata,
    output logic [LINE_W-1:0] o_c0_data,
    output logic              o_c0_r_ready,
    output logic              o_c0_w_ready,

    input  logic              i_c1_read,
    input  logic              i_c1_write,
    input  logic [ADDR_W-1:0] i_c1_addr,
    input  logic [LINE_W-1:0] i_c1_writedata,
    output logic [LINE_W-1:0] o_c1_data,
    output logic              o_c1_r_ready,
    output logic              o_c1_w_ready,

    cache_mem_arbiter_if.master mem,

    output logic              o_owner
);

    arb_state_t        state_q, state_d;
    logic              owner_q, owner_d;
    logic              ptr_q, ptr_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [1:0]        req;
    logic              grant;
    logic              win_write;

    assign req = {i_c1_read | i_c1_write, i_c0_read | i_c0_write};

    arb_rr2 u_arb_rr2 (
        .req        (req),
        .ptr        (ptr_q),
        .fixed_prio (FIXED_PRIO),
        .grant      (grant)
    );

    // Next-state logic: grant in IDLE, wait for memory completion, then
    // spend one RELEASE cycle advancing the priority pointer.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        win_write   = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    win_write   = (grant == PORT_DCACHE) ? i_c1_write : i_c0_write;
                    owner_d     = grant;
                    mem_addr_d  = (grant == PORT_DCACHE) ? i_c1_addr : i_c0_addr;
                    mem_wdata_d = (grant == PORT_DCACHE) ? i_c1_writedata : i_c0_writedata;
                    if (win_write) begin
                        mem_write_d = 1'b1;
                        state_d     = WRITE;
                    end else begin
                        mem_read_d  = 1'b1;
                        state_d     = READ;
                    end
                end
            end
            READ: begin
                if (mem.i_mem_r_ready) begin
                    mem_read_d = 1'b0;
                    state_d    = RELEASE;
                end
            end
            WRITE: begin
                if (mem.i_mem_w_ready) begin
                    mem_write_d = 1'b0;
                    state_d     = RELEASE;
                end
            end
            RELEASE: begin
`ifdef CACHE_ARB_FIXED_PRIO_EN
                ptr_d   = ptr_q;
`else
                ptr_d   = ~owner_q;
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and memory-side registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= PORT_ICACHE;
            ptr_q       <= PORT_ICACHE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem.o_mem_read      = mem_read_q;
    assign mem.o_mem_write     = mem_write_q;
    assign mem.o_mem_addr      = mem_addr_q;
    assign mem.o_mem_writedata = mem_wdata_q;

    assign o_c0_r_ready = (state_q == READ)  & mem.i_mem_r_ready & (owner_q == PORT_ICACHE);
    assign o_c1_r_ready = (state_q == READ)  & mem.i_mem_r_ready & (owner_q == PORT_DCACHE);
    assign o_c0_w_ready = (state_q == WRITE) & mem.i_mem_w_ready & (owner_q == PORT_ICACHE);
    assign o_c1_w_ready = (state_q == WRITE) & mem.i_mem_w_ready & (owner_q == PORT_DCACHE);

    assign o_c0_data = mem.i_mem_data;
    assign o_c1_data = mem.i_mem_data;

    assign o_owner = owner_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed, table-driven bench for cache_mem_arbiter. Each table row is one
// memory transaction with hand-chosen request levels and the expected winner.
// Honours CACHE_ARB_FIXED_PRIO_EN for the tie-break expectations.
module tb_cache_mem_arbiter;

    logic         clk;
    logic         reset;
    logic         i_c0_read, i_c0_write, i_c1_read, i_c1_write;
    logic [31:0]  i_c0_addr, i_c1_addr;
    logic [127:0] i_c0_writedata, i_c1_writedata;
    logic [127:0] o_c0_data, o_c1_data;
    logic         o_c0_r_ready, o_c0_w_ready, o_c1_r_ready, o_c1_w_ready;
    logic         o_owner;

    int passCount;
    int checkCount;

    cache_mem_arbiter_if #(.ADDR_W(32), .LINE_W(128)) mem_bus ();

    cache_mem_arbiter #(.ADDR_W(32), .LINE_W(128)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_c0_read      (i_c0_read),
        .i_c0_write     (i_c0_write),
        .i_c0_addr      (i_c0_addr),
        .i_c0_writedata (i_c0_writedata),
        .o_c0_data      (o_c0_data),
        .o_c0_r_ready   (o_c0_r_ready),
        .o_c0_w_ready   (o_c0_w_ready),
        .i_c1_read      (i_c1_read),
        .i_c1_write     (i_c1_write),
        .i_c1_addr      (i_c1_addr),
        .i_c1_writedata (i_c1_writedata),
        .o_c1_data      (o_c1_data),
        .o_c1_r_ready   (o_c1_r_ready),
        .o_c1_w_ready   (o_c1_w_ready),
        .mem            (mem_bus.master),
        .o_owner        (o_owner)
    );

    typedef struct {
        logic         c0_rd, c0_wr, c1_rd, c1_wr;
        logic [31:0]  a0, a1;
        logic [127:0] wd0, wd1;
        logic [127:0] mdata;
        int           lat;
        int           gap;
        logic         exp_owner;
    } vec_t;

    vec_t vecs [10];

    // Free-running clock; stimulus changes and sampling happen on the falling edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so a stuck design still ends the run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic dropRequests();
        i_c0_read  = 1'b0;
        i_c0_write = 1'b0;
        i_c1_read  = 1'b0;
        i_c1_write = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        logic         expWrite;
        logic [31:0]  expAddr;
        logic [127:0] expWdata;
        logic [3:0]   expReady;
        int           gap;
        bit           seen;

        expWrite = v.exp_owner ? v.c1_wr : v.c0_wr;
        expAddr  = v.exp_owner ? v.a1 : v.a0;
        expWdata = v.exp_owner ? v.wd1 : v.wd0;
        if (v.exp_owner == 1'b0) expReady = expWrite ? 4'b0100 : 4'b1000;
        else                     expReady = expWrite ? 4'b0001 : 4'b0010;

        i_c0_read      = v.c0_rd;
        i_c0_write     = v.c0_wr;
        i_c1_read      = v.c1_rd;
        i_c1_write     = v.c1_wr;
        i_c0_addr      = v.a0;
        i_c1_addr      = v.a1;
        i_c0_writedata = v.wd0;
        i_c1_writedata = v.wd1;

        gap  = 0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            gap++;
            if (mem_bus.o_mem_read || mem_bus.o_mem_write) seen = 1'b1;
        end
        checkOutput($sformatf("v%0d request_gap", idx), 128'(seen ? gap : 99), 128'(v.gap));
        if (!seen) begin
            dropRequests();
            return;
        end

        checkOutput($sformatf("v%0d owner", idx), 128'(o_owner), 128'(v.exp_owner));
        checkOutput($sformatf("v%0d mem_rw", idx),
                    128'({mem_bus.o_mem_read, mem_bus.o_mem_write}), 128'({~expWrite, expWrite}));
        checkOutput($sformatf("v%0d mem_addr", idx), 128'(mem_bus.o_mem_addr), 128'(expAddr));
        if (expWrite) begin
            checkOutput($sformatf("v%0d mem_writedata", idx), mem_bus.o_mem_writedata, expWdata);
        end

        i_c0_addr      = 32'hDEAD_BEEF;
        i_c1_addr      = 32'hFEED_FACE;
        i_c0_writedata = ~v.wd0;
        i_c1_writedata = ~v.wd1;

        repeat (v.lat) @(negedge clk);
        mem_bus.i_mem_data    = v.mdata;
        mem_bus.i_mem_r_ready = ~expWrite;
        mem_bus.i_mem_w_ready = expWrite;
        #1;
        checkOutput($sformatf("v%0d addr_stable", idx), 128'(mem_bus.o_mem_addr), 128'(expAddr));
        checkOutput($sformatf("v%0d ready_pulse", idx),
                    128'({o_c0_r_ready, o_c0_w_ready, o_c1_r_ready, o_c1_w_ready}), 128'(expReady));
        if (!expWrite) begin
            checkOutput($sformatf("v%0d read_data", idx),
                        v.exp_owner ? o_c1_data : o_c0_data, v.mdata);
        end

        @(negedge clk);
        mem_bus.i_mem_r_ready = 1'b0;
        mem_bus.i_mem_w_ready = 1'b0;
        mem_bus.i_mem_data    = '0;
        dropRequests();
        #1;
        checkOutput($sformatf("v%0d release_idle", idx),
                    128'({mem_bus.o_mem_read, mem_bus.o_mem_write,
                          o_c0_r_ready, o_c0_w_ready, o_c1_r_ready, o_c1_w_ready}), 128'(0));
    endtask

    // Main directed sequence.
    initial begin
        passCount  = 0;
        checkCount = 0;

        vecs[0] = '{1,0,1,0, 32'h0000_1230, 32'h0000_4560, '0, '0, {4{32'hAAAA_AAAA}}, 3, 1, 1'b0};
        vecs[1] = '{1,0,1,0, 32'h0000_2000, 32'h0000_3000, '0, '0, {4{32'hBBBB_0001}}, 2, 2, 1'b1};
        vecs[2] = '{1,0,1,0, 32'h0000_2100, 32'h0000_3100, '0, '0, {4{32'hBBBB_0002}}, 1, 2, 1'b0};
        vecs[3] = '{1,0,0,0, 32'h0000_1230, 32'h0000_0000, '0, '0, {4{32'hAAAA_AAAA}}, 3, 2, 1'b0};
        vecs[4] = '{0,0,1,1, 32'h0000_0000, 32'h0000_8880, '0, {4{32'h5555_5555}}, '0, 2, 2, 1'b1};
        vecs[5] = '{0,0,1,0, 32'h0000_0000, 32'h0000_8880, '0, '0, {4{32'h0F0F_0F0F}}, 1, 2, 1'b1};
        vecs[6] = '{0,1,1,0, 32'h0000_7770, 32'h0000_9990, {4{32'h1234_5678}}, '0, {4{32'h600D_600D}}, 2, 2, 1'b0};
        vecs[7] = '{1,0,0,1, 32'h0000_1110, 32'h0000_2220, '0, {4{32'hCAFE_F00D}}, {4{32'h7777_0000}}, 4, 2, 1'b1};
        vecs[8] = '{1,0,1,0, 32'h0000_3330, 32'h0000_4440, '0, '0, {4{32'h8888_1111}}, 2, 2, 1'b0};
        vecs[9] = '{1,0,1,0, 32'h0000_5670, 32'h0000_6780, '0, '0, {4{32'h9999_2222}}, 1, 1, 1'b0};
`ifdef CACHE_ARB_FIXED_PRIO_EN
        vecs[0].exp_owner = 1'b1;
        vecs[2].exp_owner = 1'b1;
        vecs[6].exp_owner = 1'b1;
        vecs[8].exp_owner = 1'b1;
        vecs[9].exp_owner = 1'b1;
`endif

        reset                 = 1'b0;
        dropRequests();
        i_c0_addr             = '0;
        i_c1_addr             = '0;
        i_c0_writedata        = '0;
        i_c1_writedata        = '0;
        mem_bus.i_mem_data    = '0;
        mem_bus.i_mem_r_ready = 1'b0;
        mem_bus.i_mem_w_ready = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset mem_rw", 128'({mem_bus.o_mem_read, mem_bus.o_mem_write}), 128'(0));
        checkOutput("reset mem_addr", 128'(mem_bus.o_mem_addr), 128'(0));
        checkOutput("reset mem_writedata", mem_bus.o_mem_writedata, 128'(0));
        checkOutput("reset owner", 128'(o_owner), 128'(0));
        reset = 1'b1;

        @(negedge clk);
        mem_bus.i_mem_r_ready = 1'b1;
        mem_bus.i_mem_w_ready = 1'b1;
        #1;
        checkOutput("idle ready ignored",
                    128'({o_c0_r_ready, o_c0_w_ready, o_c1_r_ready, o_c1_w_ready}), 128'(0));
        @(negedge clk);
        mem_bus.i_mem_r_ready = 1'b0;
        mem_bus.i_mem_w_ready = 1'b0;
        checkOutput("idle no request", 128'({mem_bus.o_mem_read, mem_bus.o_mem_write}), 128'(0));

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Reset in the middle of a read: the transaction is dropped silently.
        @(negedge clk);
        i_c0_read = 1'b1;
        i_c0_addr = 32'h0000_5550;
        @(negedge clk);
        checkOutput("midreset read issued", 128'(mem_bus.o_mem_read), 128'(1));
        reset = 1'b0;
        @(negedge clk);
        mem_bus.i_mem_r_ready = 1'b1;
        mem_bus.i_mem_data    = {4{32'hEEEE_EEEE}};
        #1;
        checkOutput("midreset mem_rw", 128'({mem_bus.o_mem_read, mem_bus.o_mem_write}), 128'(0));
        checkOutput("midreset mem_addr", 128'(mem_bus.o_mem_addr), 128'(0));
        checkOutput("midreset owner", 128'(o_owner), 128'(0));
        checkOutput("midreset no ready",
                    128'({o_c0_r_ready, o_c0_w_ready, o_c1_r_ready, o_c1_w_ready}), 128'(0));
        @(negedge clk);
        reset                 = 1'b1;
        mem_bus.i_mem_r_ready = 1'b0;
        mem_bus.i_mem_data    = '0;
        dropRequests();
        @(negedge clk);

        applyStimulus(vecs[9], 9);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
